// File: rtl/ex_issue_pkg.sv
// Shared definitions for the decode-and-issue stage: ALU op codes, RV32I opcodes
// and the registered issue bundle handed to the ALU and later stages.
package ex_issue_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef struct packed {
        logic [3:0]  ctl;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        illegal;
    } issue_bundle_t;

    // Register/immediate ALU op from funct3; alt is funct7[5] where it matters.
    function automatic logic [3:0] alu_op_of(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'd0:    op = alt ? ALU_SUB : ALU_ADD;
            3'd1:    op = ALU_SLL;
            3'd2:    op = ALU_SLT;
            3'd3:    op = ALU_SLTU;
            3'd4:    op = ALU_XOR;
            3'd5:    op = alt ? ALU_SRA : ALU_SRL;
            3'd6:    op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ex_issue_stage_decode.sv
// Combinational RV32I decode into the issue bundle.
// EX_ISSUE_ILLEGAL_EN adds illegal-encoding detection that squashes all side effects.
module ex_issue_decode
    import ex_issue_pkg::*;
(
    input  logic [31:0]   instr,
    input  logic [31:0]   pc,
    input  logic [31:0]   rs1_data,
    input  logic [31:0]   rs2_data,
    output issue_bundle_t bundle
);

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] i_imm;
    logic [31:0] s_imm;
    logic [31:0] b_imm;
    logic [31:0] u_imm;
    logic [31:0] j_imm;
    issue_bundle_t raw;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];
    assign i_imm  = {{20{instr[31]}}, instr[31:20]};
    assign s_imm  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign b_imm  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign u_imm  = {instr[31:12], 12'b0};
    assign j_imm  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        raw        = '0;
        raw.pc     = pc;
        raw.funct3 = f3;
        case (opcode)
            OPC_OP: begin
                raw.ctl       = alu_op_of(f3, instr[30]);
                raw.src1      = rs1_data;
                raw.src2      = rs2_data;
                raw.rd        = instr[11:7];
                raw.reg_write = 1'b1;
            end
            OPC_OP_IMM: begin
                // Only SRAI uses instr[30]; for ADDI it is an immediate bit.
                raw.ctl       = alu_op_of(f3, (f3 == 3'd5) && instr[30]);
                raw.src1      = rs1_data;
                raw.src2      = (f3 == 3'd1 || f3 == 3'd5) ? {27'b0, instr[24:20]} : i_imm;
                raw.imm       = i_imm;
                raw.rd        = instr[11:7];
                raw.reg_write = 1'b1;
            end
            OPC_LOAD: begin
                raw.ctl       = ALU_ADD;
                raw.src1      = rs1_data;
                raw.src2      = i_imm;
                raw.imm       = i_imm;
                raw.rd        = instr[11:7];
                raw.reg_write = 1'b1;
                raw.mem_read  = 1'b1;
            end
            OPC_STORE: begin
                raw.ctl       = ALU_ADD;
                raw.src1      = rs1_data;
                raw.src2      = s_imm;
                raw.imm       = s_imm;
                raw.rs2_data  = rs2_data;
                raw.mem_write = 1'b1;
            end
            OPC_BRANCH: begin
                case (f3[2:1])
                    2'b00:   raw.ctl = ALU_SUB;
                    2'b10:   raw.ctl = ALU_SLT;
                    2'b11:   raw.ctl = ALU_SLTU;
                    default: raw.ctl = ALU_ADD;
                endcase
                raw.src1   = rs1_data;
                raw.src2   = rs2_data;
                raw.imm    = b_imm;
                raw.branch = 1'b1;
            end
            OPC_LUI: begin
                raw.ctl       = ALU_ADD;
                raw.src2      = u_imm;
                raw.imm       = u_imm;
                raw.rd        = instr[11:7];
                raw.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                raw.ctl       = ALU_ADD;
                raw.src1      = pc;
                raw.src2      = u_imm;
                raw.imm       = u_imm;
                raw.rd        = instr[11:7];
                raw.reg_write = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                // The ALU produces the link value; the target uses imm.
                raw.ctl       = ALU_ADD;
                raw.src1      = pc;
                raw.src2      = 32'd4;
                raw.imm       = (opcode == OPC_JAL) ? j_imm : i_imm;
                raw.rd        = instr[11:7];
                raw.reg_write = 1'b1;
                raw.jump      = 1'b1;
            end
            default: ;
        endcase
        if (raw.rd == 5'd0) begin
            raw.reg_write = 1'b0;
        end
    end

`ifdef EX_ISSUE_ILLEGAL_EN
    logic illegal;

    always_comb begin
        illegal = 1'b0;
        case (opcode)
            OPC_OP:     illegal = !((f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
            OPC_OP_IMM: begin
                if (f3 == 3'd1) begin
                    illegal = (f7 != 7'h00);
                end else if (f3 == 3'd5) begin
                    illegal = !((f7 == 7'h00) || (f7 == 7'h20));
                end
            end
            OPC_LOAD:   illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
            OPC_STORE:  illegal = (f3 > 3'd2);
            OPC_BRANCH: illegal = (f3 == 3'd2) || (f3 == 3'd3);
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: illegal = 1'b0;
            default:    illegal = 1'b1;
        endcase
    end

    always_comb begin
        bundle = raw;
        if (illegal) begin
            bundle.illegal   = 1'b1;
            bundle.reg_write = 1'b0;
            bundle.mem_read  = 1'b0;
            bundle.mem_write = 1'b0;
            bundle.branch    = 1'b0;
            bundle.jump      = 1'b0;
        end
    end
`else
    assign bundle = raw;
`endif

endmodule

// File: rtl/ex_issue_stage.sv
// Decode-and-issue pipeline register in front of the ALU with valid/ready, stall and flush.
// Optional EX_ISSUE_ILLEGAL_EN enables illegal-instruction detection in the decoder.
module ex_issue_stage
    import ex_issue_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      out_ctl,
    output logic [XLEN-1:0] out_src1,
    output logic [XLEN-1:0] out_src2,
    output logic [XLEN-1:0] out_rs2_data,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rd,
    output logic [2:0]      out_funct3,
    output logic            out_reg_write,
    output logic            out_mem_read,
    output logic            out_mem_write,
    output logic            out_branch,
    output logic            out_jump,
    output logic            out_illegal
);

    issue_bundle_t dec_bundle;
    issue_bundle_t bundle_reg;
    logic          valid_reg;
    logic          accept;

    ex_issue_decode u_decode (
        .instr    (in_instr),
        .pc       (in_pc),
        .rs1_data (in_rs1_data),
        .rs2_data (in_rs2_data),
        .bundle   (dec_bundle)
    );

    assign in_ready = !valid_reg || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg  <= 1'b0;
            bundle_reg <= '0;
        end else begin
            if (flush) begin
                valid_reg <= 1'b0;
            end else if (accept) begin
                valid_reg <= 1'b1;
            end else if (out_ready) begin
                valid_reg <= 1'b0;
            end
            if (accept) begin
                bundle_reg <= dec_bundle;
            end
        end
    end

    assign out_valid     = valid_reg;
    assign out_ctl       = bundle_reg.ctl;
    assign out_src1      = bundle_reg.src1;
    assign out_src2      = bundle_reg.src2;
    assign out_rs2_data  = bundle_reg.rs2_data;
    assign out_imm       = bundle_reg.imm;
    assign out_pc        = bundle_reg.pc;
    assign out_rd        = bundle_reg.rd;
    assign out_funct3    = bundle_reg.funct3;
    assign out_reg_write = bundle_reg.reg_write;
    assign out_mem_read  = bundle_reg.mem_read;
    assign out_mem_write = bundle_reg.mem_write;
    assign out_branch    = bundle_reg.branch;
    assign out_jump      = bundle_reg.jump;
    assign out_illegal   = bundle_reg.illegal;

endmodule
